// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared load-type, writeback-state and reset-PC definitions
package cpu_pkg;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LW  = 3'd4;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_FULL  = 2'd1,
    WB_WAIT  = 2'd2
  } wb_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and sign/zero-extends load data from a read word
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  ltype_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Halfword misalignment is trapped upstream, so only addr_lo[1] matters.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (ltype_i)
      LT_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  result_o = {24'd0, byte_sel};
      LT_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  result_o = {16'd0, half_sel};
      LT_LW:   result_o = rdata_i;
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS writeback stage; WB_TRACE_EN adds trace ports and a retire counter
module wb_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
`ifdef WB_TRACE_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic        in_wen,
  input  logic [4:0]  in_wreg,
  input  logic [31:0] in_wdata,
  input  logic        in_load,
  input  logic [2:0]  in_ltype,
  input  logic [1:0]  in_addr_lo,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_wreg,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc
`ifdef WB_TRACE_EN
  , output logic [3:0]       debug_wb_rf_wen
  , output logic [4:0]       debug_wb_rf_wnum
  , output logic [31:0]      debug_wb_rf_wdata
  , output logic [CNT_W-1:0] retired_cnt
`endif
);

  wb_state_e   state_q, state_d;
  logic [31:0] pc_q;
  logic        wen_q;
  logic [4:0]  wreg_q;
  logic [31:0] wdata_q;
  logic [2:0]  ltype_q;
  logic [1:0]  addr_lo_q;

  logic        load_done;
  logic        retire;
  logic        accept;
  logic [31:0] load_result;

  load_align u_load_align (
    .rdata_i   (dresp_rdata),
    .ltype_i   (ltype_q),
    .addr_lo_i (addr_lo_q),
    .result_o  (load_result)
  );

  // Gating with reset discards a load whose response arrives while reset is held.
  assign load_done = (state_q == WB_WAIT) & dresp_valid;
  assign retire    = ~reset & ((state_q == WB_FULL) | load_done);
  assign in_ready  = (state_q != WB_WAIT) | dresp_valid;
  assign accept    = in_valid & in_ready;

  assign rf_wen      = retire & wen_q & (wreg_q != 5'd0);
  assign rf_wreg     = wreg_q;
  assign rf_wdata    = load_done ? load_result : wdata_q;
  assign debug_wb_pc = pc_q;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_load ? WB_WAIT : WB_FULL;
    end else if (retire) begin
      state_d = WB_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WB_EMPTY;
      pc_q      <= PC_RESET;
      wen_q     <= 1'b0;
      wreg_q    <= 5'd0;
      wdata_q   <= 32'd0;
      ltype_q   <= 3'd0;
      addr_lo_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q      <= in_pc;
        wen_q     <= in_wen;
        wreg_q    <= in_wreg;
        wdata_q   <= in_wdata;
        ltype_q   <= in_ltype;
        addr_lo_q <= in_addr_lo;
      end
    end
  end

`ifdef WB_TRACE_EN
  logic [CNT_W-1:0] retired_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_q <= '0;
    end else if (retire) begin
      retired_cnt_q <= retired_cnt_q + CNT_W'(1);
    end
  end

  assign debug_wb_rf_wen   = {4{rf_wen}};
  assign debug_wb_rf_wnum  = rf_wreg;
  assign debug_wb_rf_wdata = rf_wdata;
  assign retired_cnt       = retired_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - vector-table and scoreboard bench for wb_stage
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_wen;
  logic [4:0]  in_wreg;
  logic [31:0] in_wdata;
  logic        in_load;
  logic [2:0]  in_ltype;
  logic [1:0]  in_addr_lo;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic        rf_wen;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
`ifdef WB_TRACE_EN
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retired_cnt;
`endif

  always #5 clk = ~clk;

  wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_wen      (in_wen),
    .in_wreg     (in_wreg),
    .in_wdata    (in_wdata),
    .in_load     (in_load),
    .in_ltype    (in_ltype),
    .in_addr_lo  (in_addr_lo),
    .dresp_valid (dresp_valid),
    .dresp_rdata (dresp_rdata),
    .rf_wen      (rf_wen),
    .rf_wreg     (rf_wreg),
    .rf_wdata    (rf_wdata),
    .debug_wb_pc (debug_wb_pc)
`ifdef WB_TRACE_EN
    , .debug_wb_rf_wen   (debug_wb_rf_wen)
    , .debug_wb_rf_wnum  (debug_wb_rf_wnum)
    , .debug_wb_rf_wdata (debug_wb_rf_wdata)
    , .retired_cnt       (retired_cnt)
`endif
  );

  typedef struct {
    logic        load;
    logic [2:0]  ltype;
    logic [1:0]  addr_lo;
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } wr_t;

  vec_t vecs[14];
  wr_t  sb[$];
  wr_t  got;
  int   checks = 0;
  int   failures = 0;
  int   exp_retired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_retire(input logic en, input logic [4:0] r, input logic [31:0] d);
    wr_t w;
    w.wreg  = r;
    w.wdata = d;
    if (en) sb.push_back(w);
    exp_retired++;
  endtask

  // Writes are sampled late in each cycle and matched in order against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rf_wen !== 1'b0) begin
        if (rf_wen !== 1'b1 || sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=wen %b wreg %0d wdata %h required=no write",
                   rf_wen, rf_wreg, rf_wdata);
        end else begin
          got = sb.pop_front();
          chk("wb_wreg", {27'd0, rf_wreg}, {27'd0, got.wreg});
          chk("wb_wdata", rf_wdata, got.wdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input vec_t v, input logic [31:0] pc, input int idx);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_wen     = v.wen;
    in_wreg    = v.wreg;
    in_wdata   = v.wdata;
    in_load    = v.load;
    in_ltype   = v.ltype;
    in_addr_lo = v.addr_lo;
    dresp_valid = 1'b0;
    #1 chk($sformatf("v%0d_ready_accept", idx), {31'd0, in_ready}, 32'd1);
    expect_retire(v.exp_wen, v.wreg, v.exp_wdata);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk($sformatf("v%0d_pc", idx), debug_wb_pc, pc);
    if (v.load) begin
      for (int k = 0; k < v.delay; k++) begin
        chk($sformatf("v%0d_ready_wait%0d", idx, k), {31'd0, in_ready}, 32'd0);
        chk($sformatf("v%0d_nowen_wait%0d", idx, k), {31'd0, rf_wen}, 32'd0);
        @(negedge clk);
        #1;
      end
      dresp_valid = 1'b1;
      dresp_rdata = v.rdata;
      #1 chk($sformatf("v%0d_ready_resp", idx), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      dresp_valid = 1'b0;
    end
  endtask

  initial begin
    //          load  ltype   lo    wen   wreg   wdata         rdata         dly exp_wen exp_wdata
    vecs[0]  = '{1'b0, LT_LW,  2'd0, 1'b1, 5'd3,  32'h0000_0011, 32'h0,        0, 1'b1, 32'h0000_0011};
    vecs[1]  = '{1'b0, LT_LW,  2'd0, 1'b1, 5'd4,  32'h0000_0022, 32'h0,        0, 1'b1, 32'h0000_0022};
    vecs[2]  = '{1'b1, LT_LB,  2'd2, 1'b1, 5'd5,  32'h0,        32'h1280_3456, 3, 1'b1, 32'hFFFF_FF80};
    vecs[3]  = '{1'b1, LT_LBU, 2'd2, 1'b1, 5'd5,  32'h0,        32'h1280_3456, 3, 1'b1, 32'h0000_0080};
    vecs[4]  = '{1'b1, LT_LH,  2'd2, 1'b1, 5'd6,  32'h0,        32'h8001_7FFF, 1, 1'b1, 32'hFFFF_8001};
    vecs[5]  = '{1'b1, LT_LHU, 2'd0, 1'b1, 5'd6,  32'h0,        32'h8001_7FFF, 0, 1'b1, 32'h0000_7FFF};
    vecs[6]  = '{1'b1, LT_LW,  2'd3, 1'b1, 5'd6,  32'h0,        32'h8001_7FFF, 2, 1'b1, 32'h8001_7FFF};
    vecs[7]  = '{1'b0, LT_LW,  2'd0, 1'b1, 5'd0,  32'h0000_DEAD, 32'h0,        0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, LT_LB,  2'd0, 1'b1, 5'd31, 32'h0,        32'h1280_3456, 0, 1'b1, 32'h0000_0056};
    vecs[9]  = '{1'b1, LT_LB,  2'd3, 1'b1, 5'd31, 32'h0,        32'h1280_3456, 1, 1'b1, 32'h0000_0012};
    vecs[10] = '{1'b1, LT_LH,  2'd3, 1'b1, 5'd2,  32'h0,        32'h8001_7FFF, 0, 1'b1, 32'hFFFF_8001};
    vecs[11] = '{1'b1, 3'd7,   2'd1, 1'b1, 5'd2,  32'h0,        32'h8001_7FFF, 0, 1'b1, 32'h8001_7FFF};
    vecs[12] = '{1'b1, LT_LW,  2'd0, 1'b0, 5'd9,  32'h0,        32'h5555_AAAA, 1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, LT_LW,  2'd0, 1'b1, 5'd0,  32'h0,        32'h5555_AAAA, 0, 1'b0, 32'h0};

    reset = 1'b1; in_valid = 1'b0; in_pc = 32'd0; in_wen = 1'b0; in_wreg = 5'd0;
    in_wdata = 32'd0; in_load = 1'b0; in_ltype = 3'd0; in_addr_lo = 2'd0;
    dresp_valid = 1'b0; dresp_rdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_wreg", {27'd0, rf_wreg}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pc", debug_wb_pc, 32'hBFC0_0000);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      send(vecs[i], 32'h0000_1000 + 32'(i * 4), i);
    end
    repeat (2) @(negedge clk);
`ifdef WB_TRACE_EN
    chk("retired_cnt_table", retired_cnt, 32'(exp_retired));
`endif

    // Load parked in WAIT, then reset with a response present: no write, late response ignored.
    in_valid = 1'b1; in_load = 1'b1; in_ltype = LT_LW; in_wen = 1'b1; in_wreg = 5'd10;
    in_pc = 32'h0000_2000;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rstwait_pc", debug_wb_pc, 32'h0000_2000);
    chk("rstwait_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    dresp_valid = 1'b1;
    dresp_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 2; k++) begin
      #1 chk($sformatf("rst_nowen%0d", k), {31'd0, rf_wen}, 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    exp_retired = 0;
    #1;
    chk("rst2_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst2_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_pc", debug_wb_pc, 32'hBFC0_0000);
    chk("rst2_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    dresp_valid = 1'b0;

    // Load retires in its response cycle while an ALU op is accepted alongside it.
    in_valid = 1'b1; in_load = 1'b1; in_ltype = LT_LW; in_wen = 1'b1; in_wreg = 5'd8;
    in_pc = 32'h0000_3000; in_addr_lo = 2'd0;
    expect_retire(1'b1, 5'd8, 32'h1280_3456);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("ovl_ready_wait", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b0; in_wen = 1'b1; in_wreg = 5'd7; in_wdata = 32'h0000_0077;
    in_pc = 32'h0000_3004;
    dresp_valid = 1'b1;
    dresp_rdata = 32'h1280_3456;
    expect_retire(1'b1, 5'd7, 32'h0000_0077);
    #1 chk("ovl_ready_resp", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("ovl_pc", debug_wb_pc, 32'h0000_3004);
    @(negedge clk);
    #1 chk("ovl_stray_nowen", {31'd0, rf_wen}, 32'd0);
    chk("ovl_stray_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    dresp_valid = 1'b0;
    repeat (2) @(negedge clk);
`ifdef WB_TRACE_EN
    chk("retired_cnt_final", retired_cnt, 32'(exp_retired));
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
